filter_channel_scheduler: RTL and testbench
===========================================

FILTER_CHANNEL_SCHEDULER -- requirements
Module: filter_channel_scheduler

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of raw input channels sharing one filter engine.
REQ-002 SHALL have parameter MIN_SAME_SAMPLES, default 20: consecutive identical samples required to change a filtered level.
REQ-003 SHALL have parameter DIV_WIDTH, default 16: width of the sample prescaler.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous active-low reset (0 = reset).
REQ-006 SHALL have port enable, input, 1 bit: 1 = prescaler runs and scans start.
REQ-007 SHALL have port sample_div, input, DIV_WIDTH: sample tick period minus one, in clk cycles.
REQ-008 SHALL have port raw_in, input, N_CH: raw levels, already synchronous to clk.
REQ-009 SHALL have port filtered_out, output, N_CH: registered filtered levels.
REQ-010 SHALL have port evt_valid, output, 1 bit: level-change event pending.
REQ-011 SHALL have port evt_ready, input, 1 bit: consumer accepts event.
REQ-012 SHALL have port evt_channel, output, $clog2(N_CH): channel of pending event.
REQ-013 SHALL have port evt_level, output, 1 bit: new filtered level of pending event.
REQ-014 SHALL have port overrun, output, 1 bit: sticky; sample tick lost.

Function
REQ-015 Prescaler SHALL count 0..sample_div while enable=1, emit a one-cycle tick at sample_div, wrap to 0; held at 0 while enable=0.
REQ-016 FSM states SHALL be IDLE, SCAN, WAIT_EVT; tick in IDLE -> SCAN with channel index 0 on next cycle.
REQ-017 SCAN SHALL evaluate exactly one channel per cycle, index k; after k=N_CH-1 with no event -> IDLE.
REQ-018 Per channel: raw_in[k]==last_sample[k] -> run[k] increments, saturating at MIN_SAME_SAMPLES; else run[k]<=1, last_sample[k]<=raw_in[k].
REQ-019 When updated run[k]==MIN_SAME_SAMPLES and last_sample level != filtered_out[k], filtered_out[k] SHALL take that level on the next cycle.
REQ-020 A level change SHALL, same cycle filtered_out updates, assert evt_valid with evt_channel=k, evt_level=new level, and move FSM to WAIT_EVT.
REQ-021 In WAIT_EVT, evt_valid/evt_channel/evt_level SHALL hold stable; on evt_valid&&evt_ready, evt_valid drops next cycle and FSM -> SCAN at k+1, or IDLE if k=N_CH-1.
REQ-022 Multiple changes in one scan SHALL emit events in ascending channel order, one per handshake.
REQ-023 Tick arriving while FSM not IDLE SHALL be dropped and set overrun=1 until reset.
REQ-024 enable deasserted mid-scan SHALL not abort the current scan; no new scan starts.
REQ-025 run counters SHALL be $clog2(MIN_SAME_SAMPLES+1) bits, never wrap.
REQ-026 Pulses shorter than MIN_SAME_SAMPLES ticks SHALL never alter filtered_out.

Reset
REQ-027 reset=0 at a clk edge SHALL clear prescaler, run[], last_sample[], filtered_out, evt_valid, evt_channel, evt_level, overrun, channel index, FSM->IDLE.
REQ-028 reset in any state, including WAIT_EVT, SHALL discard the pending event with no handshake.
REQ-029 First scan after reset SHALL treat last_sample=0; constant-0 inputs produce no event.

Configuration
REQ-030 Macro FILTER_SCHED_EVENT_EN defined: event interface and WAIT_EVT per REQ-020..022.
REQ-031 Macro undefined: no WAIT_EVT state, evt_valid/evt_channel/evt_level tied 0, evt_ready ignored, scan never stalls; filtered_out behaviour unchanged.

Verification
REQ-032 Macro on, MIN=20, sample_div=9, raw_in[0] 0->1 held -> filtered_out[0]=1 after 20th tick, one event ch0 level 1.
REQ-033 raw_in[2] high for 19 ticks then low -> filtered_out[2] stays 0, no event, run[2] restarts at 1.
REQ-034 ch1 and ch3 settle to 1 in same scan, evt_ready=1 -> events ch1 then ch3, each one cycle valid.
REQ-035 evt_ready=0 for 100 cycles during event, sample_div=9 -> event fields stable, overrun=1, scan resumes after ready.
REQ-036 sample_div=0, N_CH=4 -> overrun=1 within first scan; reset=0 in WAIT_EVT -> all outputs 0, FSM IDLE next cycle.
REQ-037 Macro off, same stimulus as REQ-032 -> filtered_out[0] rises on 20th tick, evt_valid stays 0.

Source files
------------

// File: rtl/filter_channel_scheduler.sv
// Debounces N_CH raw channels through one time-shared filter engine, one channel per clock.
// Define FILTER_SCHED_EVENT_EN to add the level-change event port and the WAIT_EVT stall state.
module filter_channel_scheduler #(
    parameter int N_CH             = 4,
    parameter int MIN_SAME_SAMPLES = 20,
    parameter int DIV_WIDTH        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [DIV_WIDTH-1:0]    sample_div,
    input  logic [N_CH-1:0]         raw_in,
    output logic [N_CH-1:0]         filtered_out,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_channel,
    output logic                    evt_level,
    output logic                    overrun,
    output logic [1:0]              fsm_state
);
    localparam int IW = $clog2(N_CH);
    localparam int RW = $clog2(MIN_SAME_SAMPLES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MIN_SAME_SAMPLES);
    localparam logic [IW-1:0] LAST_CH = IW'(N_CH - 1);

`ifdef FILTER_SCHED_EVENT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, WAIT_EVT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1} state_t;
`endif

    state_t               state, state_next;
    logic [IW-1:0]        idx, idx_next;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;
    logic [N_CH-1:0]      last_sample;
    logic [RW-1:0]        run [N_CH];
    logic                 cur_raw;
    logic [RW-1:0]        cur_run;
    logic [RW-1:0]        new_run;
    logic                 change;
    logic                 last_ch;

    assign fsm_state = state;

    // >= rather than == so a sample_div lowered below the running count wraps at once.
    assign tick = enable && (div_cnt >= sample_div);

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (!enable || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    always_comb begin
        cur_raw = raw_in[idx];
        cur_run = run[idx];
        if (cur_raw != last_sample[idx]) begin
            new_run = RW'(1);
        end else if (cur_run == RUN_MAX) begin
            new_run = RUN_MAX;
        end else begin
            new_run = cur_run + RW'(1);
        end
        change  = (state == SCAN) && (new_run == RUN_MAX) && (cur_raw != filtered_out[idx]);
        last_ch = (idx == LAST_CH);
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = SCAN;
                    idx_next   = '0;
                end
            end
            SCAN: begin
                if (last_ch) begin
                    state_next = IDLE;
                end else begin
                    idx_next = idx + IW'(1);
                end
`ifdef FILTER_SCHED_EVENT_EN
                if (change) begin
                    state_next = WAIT_EVT;
                    idx_next   = idx;
                end
`endif
            end
`ifdef FILTER_SCHED_EVENT_EN
            WAIT_EVT: begin
                if (evt_valid && evt_ready) begin
                    if (last_ch) begin
                        state_next = IDLE;
                    end else begin
                        state_next = SCAN;
                        idx_next   = idx + IW'(1);
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Ticks only start scans from IDLE; any tick seen mid-scan or mid-stall is lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_sample  <= '0;
            filtered_out <= '0;
            overrun      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                run[i] <= '0;
            end
        end else begin
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if (state == SCAN) begin
                run[idx]         <= new_run;
                last_sample[idx] <= cur_raw;
                if (change) begin
                    filtered_out[idx] <= cur_raw;
                end
            end
        end
    end

`ifdef FILTER_SCHED_EVENT_EN
    // Handshake: evt_valid rises with the filtered_out update and channel/level hold
    // until a cycle with evt_valid && evt_ready; evt_valid then drops on the next edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            evt_valid   <= 1'b0;
            evt_channel <= '0;
            evt_level   <= 1'b0;
        end else if (change) begin
            evt_valid   <= 1'b1;
            evt_channel <= idx;
            evt_level   <= cur_raw;
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end
`else
    logic unused_evt_ready;
    assign unused_evt_ready = evt_ready;
    assign evt_valid        = 1'b0;
    assign evt_channel      = '0;
    assign evt_level        = 1'b0;
`endif

endmodule

// File: tb/tb_filter_channel_scheduler.sv
// Bench for filter_channel_scheduler: random and directed sample streams checked against a
// sample-history reference model and an expected-event queue.
module tb_filter_channel_scheduler;
    localparam int N_CH = 4;
    localparam int MIN  = 20;
    localparam int DW   = 16;
    localparam int EW   = 3;
`ifdef FILTER_SCHED_EVENT_EN
    localparam logic EVT_ON = 1'b1;
`else
    localparam logic EVT_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [DW-1:0]   sample_div;
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] filtered_out;
    logic            evt_valid;
    logic            evt_ready;
    logic [1:0]      evt_channel;
    logic            evt_level;
    logic            overrun;
    logic [1:0]      fsm_state;

    int              n_vec = 0;
    int              n_err = 0;
    int              period = 10;
    bit              mon_en = 1'b0;
    logic            m_ovr;
    logic [N_CH-1:0] m_filt;
    logic [N_CH-1:0] samp_q[$];
    logic [EW-1:0]   exp_q[$];
    logic [EW-1:0]   obs_q[$];

    always #5 clk = ~clk;

    filter_channel_scheduler #(.N_CH(N_CH), .MIN_SAME_SAMPLES(MIN), .DIV_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_div(sample_div),
        .raw_in(raw_in), .filtered_out(filtered_out), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_channel(evt_channel), .evt_level(evt_level),
        .overrun(overrun), .fsm_state(fsm_state)
    );

    always @(negedge clk) begin
        if (mon_en && evt_valid === 1'b1) obs_q.push_back({evt_channel, evt_level});
    end

    // A channel's filtered level becomes v once its last MIN samples are all v.
    function automatic void model_scan(input logic [N_CH-1:0] v);
        samp_q.push_back(v);
        if (samp_q.size() >= MIN) begin
            for (int k = 0; k < N_CH; k++) begin
                int ones;
                ones = 0;
                for (int j = samp_q.size() - MIN; j < samp_q.size(); j++) ones += int'(samp_q[j][k]);
                if ((ones == MIN && !m_filt[k]) || (ones == 0 && m_filt[k])) begin
                    m_filt[k] = ~m_filt[k];
                    if (EVT_ON) exp_q.push_back({k[1:0], m_filt[k]});
                end
            end
        end
    endfunction

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; evt_ready = 1'b1; raw_in = '0; sample_div = DW'(9);
        mon_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        samp_q.delete(); exp_q.delete(); obs_q.delete();
        m_filt = '0; m_ovr = 1'b0;
    endtask

    // Leaves the bench 1 time unit after the edge on which the first scan begins.
    task automatic start_scanning(input int div);
        do_reset();
        sample_div = DW'(div);
        period = div + 1;
        enable = 1'b1;
        mon_en = 1'b1;
        repeat (period) @(posedge clk);
        #1;
    endtask

    task automatic scan_period(input logic [N_CH-1:0] v, input string tag);
        bit ev_ok;
        raw_in = v;
        model_scan(v);
        repeat (period) @(posedge clk);
        #1;
        n_vec++;
        if (filtered_out !== m_filt) begin
            n_err++;
            $display("FAIL %s filtered_out: got %b expected %b", tag, filtered_out, m_filt);
        end
        n_vec++;
        if (overrun !== m_ovr) begin
            n_err++;
            $display("FAIL %s overrun: got %b expected %b", tag, overrun, m_ovr);
        end
        ev_ok = (obs_q.size() == exp_q.size());
        for (int i = 0; ev_ok && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) ev_ok = 1'b0;
        n_vec++;
        if (!ev_ok) begin
            n_err++;
            $display("FAIL %s events: got %0d events expected %0d (or order/content differs)",
                     tag, obs_q.size(), exp_q.size());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (filtered_out !== '0) begin n_err++; $display("FAIL reset filtered_out: got %b expected 0", filtered_out); end
        n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset evt_valid: got %b expected 0", evt_valid); end
        n_vec++; if (evt_channel !== 2'd0) begin n_err++; $display("FAIL reset evt_channel: got %0d expected 0", evt_channel); end
        n_vec++; if (evt_level !== 1'b0) begin n_err++; $display("FAIL reset evt_level: got %b expected 0", evt_level); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset overrun: got %b expected 0", overrun); end
        n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL reset fsm_state: got %0d expected 0", fsm_state); end
    endtask

    task automatic test_settle_ch0();
        start_scanning(9);
        for (int i = 0; i < 25; i++) scan_period(4'b0001, "settle_ch0");
    endtask

    task automatic test_glitch();
        start_scanning(9);
        for (int i = 0; i < 19; i++) scan_period(4'b0100, "glitch_hi19");
        scan_period(4'b0000, "glitch_lo");
        for (int i = 0; i < 19; i++) scan_period(4'b0100, "glitch_hi19b");
        for (int i = 0; i < 6; i++) scan_period(4'b0000, "glitch_lo6");
        for (int i = 0; i < 21; i++) scan_period(4'b0100, "glitch_settle");
    endtask

    task automatic test_two_channels();
        start_scanning(9);
        for (int i = 0; i < 22; i++) scan_period(4'b1010, "two_channels");
        for (int i = 0; i < 21; i++) scan_period(4'b0000, "two_channels_fall");
    endtask

    task automatic test_random();
        logic [N_CH-1:0] v;
        for (int r = 0; r < 2; r++) begin
            start_scanning(int'($urandom_range(8, 15)));
            v = N_CH'($urandom_range(0, 15));
            for (int i = 0; i < 70; i++) begin
                for (int k = 0; k < N_CH; k++) if ($urandom_range(0, 11) == 0) v[k] = ~v[k];
                scan_period(v, "random");
            end
        end
    endtask

`ifdef FILTER_SCHED_EVENT_EN
    task automatic test_stall();
        start_scanning(9);
        for (int i = 0; i < 19; i++) scan_period(4'b0001, "stall_pre");
        mon_en = 1'b0;
        evt_ready = 1'b0;
        model_scan(4'b0001);
        @(posedge clk); #1;
        n_vec++;
        if (evt_valid !== 1'b1 || evt_channel !== 2'd0 || evt_level !== 1'b1 || filtered_out !== 4'b0001) begin
            n_err++;
            $display("FAIL stall_event: got v=%b ch=%0d lvl=%b filt=%b expected v=1 ch=0 lvl=1 filt=0001",
                     evt_valid, evt_channel, evt_level, filtered_out);
        end
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (evt_valid !== 1'b1 || evt_channel !== 2'd0 || evt_level !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d: got v=%b ch=%0d lvl=%b expected v=1 ch=0 lvl=1",
                         c, evt_valid, evt_channel, evt_level);
            end
        end
        m_ovr = 1'b1;
        n_vec++;
        if (overrun !== 1'b1) begin n_err++; $display("FAIL stall_overrun: got %b expected 1", overrun); end
        evt_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL stall_release: evt_valid got %b expected 0", evt_valid); end
        repeat (period - (102 % period)) @(posedge clk);
        #1;
        exp_q.delete(); obs_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 22; i++) scan_period(4'b0000, "stall_resume");
    endtask
`endif

    task automatic test_overrun_reset();
        int cyc;
        do_reset();
        sample_div = '0; raw_in = 4'b0001; evt_ready = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first_tick: got %b expected 0", overrun); end
        @(posedge clk); #1;
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_in_scan: got %b expected 1", overrun); end
        cyc = 0;
        while (filtered_out[0] !== 1'b1 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++; if (cyc >= 500) begin n_err++; $display("FAIL ovr_settle timeout: waited %0d cycles, expected < 500", cyc); end
        n_vec++;
        if (evt_valid !== EVT_ON || evt_level !== EVT_ON || evt_channel !== 2'd0) begin
            n_err++;
            $display("FAIL ovr_evt: got v=%b lvl=%b ch=%0d expected v=%b lvl=%b ch=0",
                     evt_valid, evt_level, evt_channel, EVT_ON, EVT_ON);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (filtered_out !== '0 || evt_valid !== 1'b0 || evt_channel !== 2'd0 || evt_level !== 1'b0 ||
            overrun !== 1'b0 || fsm_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_in_wait: got filt=%b v=%b ch=%0d lvl=%b ovr=%b st=%0d expected all 0",
                     filtered_out, evt_valid, evt_channel, evt_level, overrun, fsm_state);
        end
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_discard: evt_valid got %b expected 0", evt_valid); end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_settle_ch0();
        test_glitch();
        test_two_channels();
        test_random();
`ifdef FILTER_SCHED_EVENT_EN
        test_stall();
`endif
        test_overrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
